// File: rtl/sonar_pkg.sv
// Shared constants, state encoding and the timebase helper for the ultrasonic ranger.
package sonar_pkg;

  localparam int unsigned DIST_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_TRIG      = 3'd1;
  localparam state_t ST_WAIT_RISE = 3'd2;
  localparam state_t ST_MEASURE   = 3'd3;
  localparam state_t ST_HOLD      = 3'd4;

  // Clocks per microsecond tick.
  function automatic int unsigned presc_count(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Two-flop synchronizer for the echo pin followed by a registered edge detector.
module sonar_echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic ech,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = ech;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width timing in us, conversion to cm.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned clk_freq   = 100_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned PERIOD_US  = 60_000,
  parameter int unsigned TIMEOUT_US = 38_000,
  parameter int unsigned CM_DIV     = 58
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ech,
  output logic              trig,
  output logic [DIST_W-1:0] distance_cm,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int unsigned PRESC   = presc_count(clk_freq);
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned SUB_W   = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;
  // Wide enough for the longest possible cycle (trigger + two full timeouts).
  localparam int unsigned CNT_W   = $clog2(PERIOD_US + TRIG_US + 2 * TIMEOUT_US + 1);

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]    per_q, per_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [DIST_W-1:0]   cm_q, cm_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic                trig_q, trig_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;

  logic                us_tick_c;
  logic                rise_c, fall_c;
  logic [SUB_W-1:0]    sub_inc_c;
  logic [DIST_W-1:0]   cm_inc_c;

  sonar_echo_sync u_echo_sync (
    .clk    (clk),
    .rst    (rst),
    .ech    (ech),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign us_tick_c = (presc_q == PRESC_W'(PRESC - 1));

  // cm counter value including the current cycle's tick, saturating.
  always_comb begin
    sub_inc_c = sub_q;
    cm_inc_c  = cm_q;
    if (us_tick_c) begin
      if (sub_q == SUB_W'(CM_DIV - 1)) begin
        sub_inc_c = '0;
        if (cm_q != '1) cm_inc_c = cm_q + DIST_W'(1);
      end else begin
        sub_inc_c = sub_q + SUB_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tmr_d     = tmr_q;
    per_d     = per_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    dist_d    = dist_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    // Prescaler held at zero in IDLE so the first trigger is exactly TRIG_US ticks.
    if (state_q == ST_IDLE || us_tick_c) presc_d = '0;
    else                                 presc_d = presc_q + PRESC_W'(1);

    if (us_tick_c && per_q != '1) per_d = per_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        state_d = ST_TRIG;
        tmr_d   = '0;
        per_d   = '0;
        sub_d   = '0;
        cm_d    = '0;
      end
      ST_TRIG: begin
        if (us_tick_c) begin
          if (tmr_q == CNT_W'(TRIG_US - 1)) begin
            state_d = ST_WAIT_RISE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_RISE: begin
        if (rise_c) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (us_tick_c) begin
          if (tmr_q == CNT_W'(TIMEOUT_US - 1)) begin
            state_d   = ST_HOLD;
            timeout_d = 1'b1;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
      end
      ST_MEASURE: begin
        sub_d = sub_inc_c;
        cm_d  = cm_inc_c;
        // A fall wins over a coincident timeout so valid and timeout never overlap.
        if (fall_c) begin
          dist_d  = cm_inc_c;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (us_tick_c) begin
          if (tmr_q == CNT_W'(TIMEOUT_US - 1)) begin
            state_d   = ST_HOLD;
            timeout_d = 1'b1;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (us_tick_c && per_q >= CNT_W'(PERIOD_US - 1)) begin
          state_d = ST_TRIG;
          tmr_d   = '0;
          per_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    trig_d = (state_d == ST_TRIG);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tmr_q     <= '0;
      per_q     <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      dist_q    <= '0;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tmr_q     <= tmr_d;
      per_q     <= per_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      dist_q    <= dist_d;
      trig_q    <= trig_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign trig        = trig_q;
  assign distance_cm = dist_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger: default timing, shortened timeouts, and a 4 MHz timebase.
module tb_sonar_ranger;

  localparam int OB_TRIG  = 0;
  localparam int OB_VALID = 1;
  localparam int OB_TO    = 2;
  localparam int OB_BUSY  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // A: default periods at 1 MHz; B: shortened timeout/period; C: 4 MHz timebase.
  logic        rst_a = 1'b0, ech_a = 1'b0;
  logic        rst_b = 1'b0, ech_b = 1'b0;
  logic        rst_c = 1'b0, ech_c = 1'b0;
  logic        trig_a, valid_a, timeout_a, busy_a;
  logic        trig_b, valid_b, timeout_b, busy_b;
  logic        trig_c, valid_c, timeout_c, busy_c;
  logic [15:0] dist_a, dist_b, dist_c;
  logic [3:0]  obs_a, obs_b, obs_c;

  assign obs_a = {busy_a, timeout_a, valid_a, trig_a};
  assign obs_b = {busy_b, timeout_b, valid_b, trig_b};
  assign obs_c = {busy_c, timeout_c, valid_c, trig_c};

  sonar_ranger #(.clk_freq(1_000_000)) u_dut_a (
    .clk(clk), .rst(rst_a), .ech(ech_a), .trig(trig_a), .distance_cm(dist_a),
    .valid(valid_a), .timeout(timeout_a), .busy(busy_a)
  );

  sonar_ranger #(.clk_freq(1_000_000), .TIMEOUT_US(6000), .PERIOD_US(6500)) u_dut_b (
    .clk(clk), .rst(rst_b), .ech(ech_b), .trig(trig_b), .distance_cm(dist_b),
    .valid(valid_b), .timeout(timeout_b), .busy(busy_b)
  );

  sonar_ranger #(.clk_freq(4_000_000)) u_dut_c (
    .clk(clk), .rst(rst_c), .ech(ech_c), .trig(trig_c), .distance_cm(dist_c),
    .valid(valid_c), .timeout(timeout_c), .busy(busy_c)
  );

  int overlap = 0;
  int vcnt_b  = 0;
  always @(negedge clk) begin
    if ((valid_a && timeout_a) || (valid_b && timeout_b) || (valid_c && timeout_c))
      overlap <= overlap + 1;
    if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs_of(input int d);
    case (d)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  // Wait up to max_cyc clocks for observed bit b of DUT d to reach lvl; t = cycle it did.
  task automatic wait_for(input int d, input int b, input logic lvl, input int max_cyc,
                          input string tag, output int unsigned t);
    logic [3:0] o;
    logic       hit;
    hit = 1'b0;
    t   = cyc;
    for (int n = 0; n < max_cyc && !hit; n++) begin
      @(posedge clk);
      #1;
      o = obs_of(d);
      if (o[b] === lvl) begin
        hit = 1'b1;
        t   = cyc;
      end
    end
    check({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  task automatic run_a();
    int unsigned t0, tr1, tf1, tto, ttoe, tr2, tf2, te, tv;
    rst_a = 1'b0;
    ech_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_trig",    32'(trig_a),    32'd0);
    check("a_rst_busy",    32'(busy_a),    32'd0);
    check("a_rst_dist",    32'(dist_a),    32'd0);
    check("a_rst_valid",   32'(valid_a),   32'd0);
    check("a_rst_timeout", 32'(timeout_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    t0 = cyc;
    wait_for(0, OB_TRIG, 1'b1, 5, "a_trig_rise", tr1);
    check("a_trig_lat", 32'(tr1 - t0), 32'd1);
    wait_for(0, OB_TRIG, 1'b0, 20, "a_trig_fall", tf1);
    check("a_trig_width", 32'(tf1 - tr1), 32'd10);
    wait_for(0, OB_TO, 1'b1, 40000, "a_noecho_to", tto);
    check("a_noecho_to_lat", 32'(tto - tf1), 32'd38000);
    check("a_to_busy", 32'(busy_a), 32'd1);
    check("a_to_dist", 32'(dist_a), 32'd0);
    wait_for(0, OB_TO, 1'b0, 5, "a_to_end", ttoe);
    check("a_to_width", 32'(ttoe - tto), 32'd1);
    wait_for(0, OB_TRIG, 1'b1, 25000, "a_retrig", tr2);
    check("a_period", 32'(tr2 - tr1), 32'd60000);
    wait_for(0, OB_TRIG, 1'b0, 20, "a_trig_fall2", tf2);
    ech_a = 1'b1;
    repeat (12500) @(posedge clk);
    #1;
    ech_a = 1'b0;
    te = cyc;
    wait_for(0, OB_VALID, 1'b1, 10, "a_valid", tv);
    check("a_valid_lat", 32'(tv - te), 32'd3);
    check("a_dist_12500", 32'(dist_a), 32'd215);
    @(posedge clk);
    #1;
    check("a_valid_width", 32'(valid_a), 32'd0);
  endtask

  task automatic b_echo(input int w, input int exp_cm);
    int unsigned tr, tf, te, tv;
    wait_for(1, OB_TRIG, 1'b1, 7000, $sformatf("b_w%0d_trig", w), tr);
    wait_for(1, OB_TRIG, 1'b0, 20, $sformatf("b_w%0d_trigfall", w), tf);
    ech_b = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    ech_b = 1'b0;
    te = cyc;
    wait_for(1, OB_VALID, 1'b1, 10, $sformatf("b_w%0d_valid", w), tv);
    check($sformatf("b_w%0d_lat", w), 32'(tv - te), 32'd3);
    check($sformatf("b_w%0d_dist", w), 32'(dist_b), 32'(exp_cm));
  endtask

  task automatic run_b();
    int unsigned t0, t, tr, tf, ta, tto, tr2, tf2, tto2, tr3;
    int v0;
    rst_b = 1'b0;
    ech_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    b_echo(57, 0);
    b_echo(58, 1);
    b_echo(5800, 100);

    // Echo stays high: measurement abandoned, distance kept, period unaffected.
    wait_for(1, OB_TRIG, 1'b1, 7000, "b_hi_trig", tr);
    wait_for(1, OB_TRIG, 1'b0, 20, "b_hi_trigfall", tf);
    ech_b = 1'b1;
    ta = cyc;
    wait_for(1, OB_TO, 1'b1, 7000, "b_meas_to", tto);
    check("b_meas_to_lat", 32'(tto - ta), 32'd6003);
    check("b_meas_to_dist", 32'(dist_b), 32'd100);
    check("b_meas_to_valid", 32'(valid_b), 32'd0);
    wait_for(1, OB_TRIG, 1'b1, 1000, "b_hi_retrig", tr2);
    check("b_hi_period", 32'(tr2 - tr), 32'd6500);

    // Stale high level at WAIT_RISE entry is not a rise.
    wait_for(1, OB_TRIG, 1'b0, 20, "b_stale_trigfall", tf2);
    wait_for(1, OB_TO, 1'b1, 7000, "b_stale_to", tto2);
    check("b_stale_to_lat", 32'(tto2 - tf2), 32'd6000);
    v0 = vcnt_b;
    ech_b = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("b_hold_fall_valids", 32'(vcnt_b), 32'(v0));
    check("b_hold_dist", 32'(dist_b), 32'd100);
    check("b_hold_busy", 32'(busy_b), 32'd1);
    wait_for(1, OB_TRIG, 1'b1, 1000, "b_stale_retrig", tr3);
    check("b_stale_period", 32'(tr3 - tr2), 32'd6500);

    // Asynchronous reset in the middle of a measurement.
    wait_for(1, OB_TRIG, 1'b0, 20, "b_rst_trigfall", tf);
    ech_b = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("b_pre_rst_busy", 32'(busy_b), 32'd1);
    rst_b = 1'b0;
    #1;
    check("b_rst_trig",  32'(trig_b),  32'd0);
    check("b_rst_busy",  32'(busy_b),  32'd0);
    check("b_rst_dist",  32'(dist_b),  32'd0);
    check("b_rst_valid", 32'(valid_b), 32'd0);
    ech_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    t0 = cyc;
    wait_for(1, OB_TRIG, 1'b1, 5, "b_post_rst_trig", t);
    check("b_post_rst_lat", 32'(t - t0), 32'd1);
  endtask

  task automatic run_c();
    int unsigned t0, tr, tf, te, tv;
    rst_c = 1'b0;
    ech_c = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    t0 = cyc;
    wait_for(2, OB_TRIG, 1'b1, 5, "c_trig_rise", tr);
    check("c_trig_lat", 32'(tr - t0), 32'd1);
    wait_for(2, OB_TRIG, 1'b0, 100, "c_trig_fall", tf);
    check("c_trig_width", 32'(tf - tr), 32'd40);
    ech_c = 1'b1;
    repeat (1600) @(posedge clk);
    #1;
    ech_c = 1'b0;
    te = cyc;
    wait_for(2, OB_VALID, 1'b1, 10, "c_valid", tv);
    check("c_valid_lat", 32'(tv - te), 32'd3);
    check("c_dist_400us", 32'(dist_c), 32'd6);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run still going at cycle %0d, limit 95000", cyc);
    $fatal(1);
  end

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    check("valid_timeout_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
